// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared codebase packages (Types, Parameters, PCType) and the fetch-local FetchType.
package Types;
    typedef logic [31:0] addr_t;
endpackage

package Parameters;
    localparam Types::addr_t InstStartFrom = 32'h0040_0000;
endpackage

package PCType;
    typedef enum logic [1:0] {NONE, INC, LOAD} pc_cmd_t;
endpackage

package FetchType;
    typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} fetch_state_t;
    localparam logic [1:0] ALIGN_MASK = 2'b11;
    function automatic logic misaligned(input logic [1:0] lsb);
        return |(lsb & ALIGN_MASK);
    endfunction
endpackage

// File: rtl/fetch_perf_counter.sv
// fetch_perf_counter: 32-bit event counter with increment enable, wrapping modulo 2^32.
module fetch_perf_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    output logic [31:0] count_o
);
    logic [31:0] count_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count_q <= '0;
        else if (inc_i) count_q <= count_q + 32'd1;
    end
    assign count_o = count_q;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: fetch stage between the PC register and decode, with a req/ack instruction memory port.
// Defining INST_FETCH_PERF_EN adds the perf_fetched / perf_stall counter outputs.
module inst_fetch
    import Types::*, PCType::*, FetchType::*;
#(
    parameter int ADDR_W = $bits(addr_t),
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    output pc_cmd_t           pc_cmd,
    output logic [ADDR_W-1:0] load_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              imem_err,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic              fault
`ifdef INST_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);
    fetch_state_t      state_q;
    logic              squash_q, inst_valid_q, fault_q;
    logic [INST_W-1:0] inst_q;
    logic [ADDR_W-1:0] addr_q;
    logic              redir, bad_redir, accept;

    // A squashed request keeps its original address even though the PC has already been reloaded.
    always_comb begin
        redir     = rst && redirect_valid && state_q != FAULT;
        bad_redir = redir && misaligned(redirect_pc[1:0]);
        accept    = state_q == REQ && imem_ack && !squash_q && !imem_err && !redirect_valid;
        imem_req  = state_q == REQ;
        imem_addr = squash_q ? addr_q : pc;
        pc_cmd    = redir && !bad_redir ? LOAD : accept ? INC : NONE;
        load_pc   = redir && !bad_redir ? redirect_pc : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            squash_q     <= 1'b0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            addr_q       <= '0;
        end else begin
            addr_q <= imem_addr;
            if (bad_redir) begin
                state_q      <= FAULT;
                fault_q      <= 1'b1;
                inst_valid_q <= 1'b0;
                squash_q     <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: state_q <= REQ;
                    REQ: begin
                        if (imem_ack) begin
                            squash_q <= 1'b0;
                            if (accept) begin
                                inst_q       <= imem_rdata;
                                inst_valid_q <= 1'b1;
                                state_q      <= HOLD;
                            end else if (!squash_q && !redirect_valid) begin
                                fault_q <= 1'b1;
                                state_q <= FAULT;
                            end
                        end else if (redirect_valid) begin
                            squash_q <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (redirect_valid || inst_ready) begin
                            inst_valid_q <= 1'b0;
                            state_q      <= REQ;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign fault      = fault_q;

`ifdef INST_FETCH_PERF_EN
    fetch_perf_counter u_fetched (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (accept),
        .count_o (perf_fetched)
    );
    fetch_perf_counter u_stall (
        .clk     (clk),
        .rst     (rst),
        .inc_i   ((state_q == REQ && !imem_ack) || (state_q == HOLD && !inst_ready)),
        .count_o (perf_stall)
    );
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed scenarios plus a randomized run checked against a transaction-level fetch model.
module tb_inst_fetch;
    import PCType::*;
    localparam logic [31:0] START = Parameters::InstStartFrom;

    logic        clk = 1'b0, rst = 1'b0;
    logic [31:0] pc, load_pc, redirect_pc, imem_addr, imem_rdata, inst;
    logic        redirect_valid, imem_req, imem_ack, imem_err, inst_valid, inst_ready, fault;
    pc_cmd_t     pc_cmd;
`ifdef INST_FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall;
`endif
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_cmd(pc_cmd), .load_pc(load_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .imem_err(imem_err),
        .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready), .fault(fault)
`ifdef INST_FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
    );

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Emulates the upstream PC register following the command seen just before the edge.
    task automatic step();
        pc_cmd_t     c;
        logic [31:0] l;
        c = pc_cmd;
        l = load_pc;
        @(posedge clk);
        #1;
        if (c == INC) pc = pc + 32'd4;
        else if (c == LOAD) pc = l;
    endtask

    task automatic do_reset();
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_ack = 1'b0; imem_err = 1'b0;
        imem_rdata = '0; inst_ready = 1'b0; pc = START;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; pc = START; redirect_valid = 1'b1; redirect_pc = 32'h0040_0200;
        imem_ack = 1'b1; imem_err = 1'b0; imem_rdata = 32'h1234_5678; inst_ready = 1'b1;
        #12;
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", imem_req); end
        tests++; if (pc_cmd !== NONE) begin fails++; $display("FAIL reset_cmd: got %0d want NONE", pc_cmd); end
        tests++; if (load_pc !== 32'h0) begin fails++; $display("FAIL reset_load_pc: got %h want 0", load_pc); end
        tests++; if (inst !== 32'h0) begin fails++; $display("FAIL reset_inst: got %h want 0", inst); end
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        tests++; if (fault !== 1'b0) begin fails++; $display("FAIL reset_fault: got %b want 0", fault); end
    endtask

    task automatic test_zero_wait();
        do_reset();
        imem_rdata = 32'h8C02_0004; inst_ready = 1'b1; imem_ack = 1'b1;
        #1;
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL zw_idle_req: got %b want 0", imem_req); end
        tests++; if (pc_cmd !== NONE) begin fails++; $display("FAIL zw_idle_cmd: got %0d want NONE", pc_cmd); end
        step();
        #1;
        tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL zw_req: got %b want 1", imem_req); end
        tests++; if (imem_addr !== START) begin fails++; $display("FAIL zw_addr: got %h want %h", imem_addr, START); end
        tests++; if (pc_cmd !== INC) begin fails++; $display("FAIL zw_inc: got %0d want INC", pc_cmd); end
        step();
        imem_ack = 1'b0;
        #1;
        tests++; if (inst_valid !== 1'b1) begin fails++; $display("FAIL zw_valid: got %b want 1", inst_valid); end
        tests++; if (inst !== 32'h8C02_0004) begin fails++; $display("FAIL zw_inst: got %h want 8c020004", inst); end
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL zw_hold_req: got %b want 0", imem_req); end
        step();
    endtask

    task automatic test_delayed_ack();
        inst_ready = 1'b0; imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL dly_req[%0d]: got %b want 1", i, imem_req); end
            tests++; if (imem_addr !== START + 32'd4) begin fails++; $display("FAIL dly_addr[%0d]: got %h want %h", i, imem_addr, START + 32'd4); end
            tests++; if (pc_cmd !== NONE) begin fails++; $display("FAIL dly_cmd[%0d]: got %0d want NONE", i, pc_cmd); end
            step();
        end
        imem_ack = 1'b1; imem_rdata = 32'h2108_0001;
        #1;
        tests++; if (pc_cmd !== INC) begin fails++; $display("FAIL dly_inc: got %0d want INC", pc_cmd); end
        step();
        imem_ack = 1'b0;
        #1;
        tests++; if (pc_cmd !== NONE) begin fails++; $display("FAIL dly_single_inc: got %0d want NONE", pc_cmd); end
    endtask

    task automatic test_hold_redirect();
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++; if (inst_valid !== 1'b1 || inst !== 32'h2108_0001) begin fails++; $display("FAIL hold_inst[%0d]: got %b/%h want 1/21080001", i, inst_valid, inst); end
            tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL hold_req[%0d]: got %b want 0", i, imem_req); end
            step();
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0040_0200; inst_ready = 1'b1;
        #1;
        tests++; if (pc_cmd !== LOAD) begin fails++; $display("FAIL hold_load: got %0d want LOAD", pc_cmd); end
        tests++; if (load_pc !== 32'h0040_0200) begin fails++; $display("FAIL hold_load_pc: got %h want 00400200", load_pc); end
        step();
        redirect_valid = 1'b0; inst_ready = 1'b0;
        #1;
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL hold_squash: got %b want 0", inst_valid); end
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0200) begin fails++; $display("FAIL hold_refetch: got %b/%h want 1/00400200", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_pending();
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h0040_0100;
        #1;
        tests++; if (pc_cmd !== LOAD) begin fails++; $display("FAIL rp_load: got %0d want LOAD", pc_cmd); end
        tests++; if (load_pc !== 32'h0040_0100) begin fails++; $display("FAIL rp_load_pc: got %h want 00400100", load_pc); end
        step();
        redirect_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        tests++; if (imem_addr !== 32'h0040_0200) begin fails++; $display("FAIL rp_addr_held: got %h want 00400200", imem_addr); end
        tests++; if (pc_cmd !== NONE) begin fails++; $display("FAIL rp_no_inc: got %0d want NONE", pc_cmd); end
        step();
        imem_ack = 1'b0;
        #1;
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL rp_valid: got %b want 0", inst_valid); end
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0100) begin fails++; $display("FAIL rp_new_req: got %b/%h want 1/00400100", imem_req, imem_addr); end
        step();
    endtask

    task automatic test_bus_error();
        imem_ack = 1'b1; imem_err = 1'b1;
        #1;
        tests++; if (pc_cmd !== NONE) begin fails++; $display("FAIL err_cmd: got %0d want NONE", pc_cmd); end
        step();
        imem_ack = 1'b0; imem_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            redirect_valid = i == 1; redirect_pc = 32'h0040_0300;
            #1;
            tests++; if (fault !== 1'b1) begin fails++; $display("FAIL err_fault[%0d]: got %b want 1", i, fault); end
            tests++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin fails++; $display("FAIL err_quiet[%0d]: got req=%b valid=%b want 0/0", i, imem_req, inst_valid); end
            tests++; if (pc_cmd !== NONE) begin fails++; $display("FAIL err_cmd[%0d]: got %0d want NONE", i, pc_cmd); end
            step();
        end
        redirect_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        tests++; if (fault !== 1'b0) begin fails++; $display("FAIL err_async_clear: got %b want 0", fault); end
    endtask

    task automatic test_misaligned();
        do_reset();
        #1 step();
        imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
        #1;
        tests++; if (pc_cmd !== INC) begin fails++; $display("FAIL mis_pre_inc: got %0d want INC", pc_cmd); end
        step();
        imem_ack = 1'b0; inst_ready = 1'b1;
        #1 step();
        inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0040_0102;
        #1;
        tests++; if (pc_cmd !== NONE) begin fails++; $display("FAIL mis_no_load: got %0d want NONE", pc_cmd); end
        step();
        redirect_valid = 1'b0;
        #1;
        tests++; if (fault !== 1'b1 || imem_req !== 1'b0) begin fails++; $display("FAIL mis_fault: got fault=%b req=%b want 1/0", fault, imem_req); end
        imem_ack = 1'b1;
        #1;
        tests++; if (pc_cmd !== NONE) begin fails++; $display("FAIL mis_late_ack: got %0d want NONE", pc_cmd); end
        step();
        imem_ack = 1'b0;
`ifdef INST_FETCH_PERF_EN
        #1;
        tests++; if (perf_fetched !== 32'd1) begin fails++; $display("FAIL mis_perf: got %0d want 1", perf_fetched); end
`endif
    endtask

    // Transaction-level model: each accepted fetch must come from the next sequential or redirected address.
    task automatic test_random();
        logic [31:0] exp_next, req_addr, held_word;
        logic        outstanding, tainted, held, fault_m, aligned, acc;
        logic [1:0]  lsb;
        pc_cmd_t     exp_cmd;
        int          delay, idle_run;
        for (int seg = 0; seg < 8; seg++) begin
            do_reset();
            exp_next = START; req_addr = '0; held_word = '0;
            outstanding = 1'b0; tainted = 1'b0; held = 1'b0; fault_m = 1'b0; delay = 0; idle_run = 0;
            for (int n = 0; n < 250; n++) begin
                inst_ready = $urandom_range(0, 2) != 0;
                redirect_valid = $urandom_range(0, 9) == 0;
                lsb = ($urandom_range(0, 29) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                redirect_pc = {START[31:12], 10'($urandom_range(0, 1023)), lsb};
                imem_ack = 1'b0; imem_err = 1'b0; imem_rdata = $urandom;
                #1;
                tests++; if (fault !== fault_m) begin fails++; $display("FAIL rnd_fault s%0d c%0d: got %b want %b", seg, n, fault, fault_m); end
                tests++; if (inst_valid !== held) begin fails++; $display("FAIL rnd_valid s%0d c%0d: got %b want %b", seg, n, inst_valid, held); end
                if (held) begin
                    tests++; if (inst !== held_word) begin fails++; $display("FAIL rnd_inst s%0d c%0d: got %h want %h", seg, n, inst, held_word); end
                end
                if (fault_m || held) begin
                    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rnd_quiet s%0d c%0d: got req %b want 0", seg, n, imem_req); end
                end else begin
                    idle_run = imem_req ? 0 : idle_run + 1;
                    tests++; if (idle_run > 1) begin fails++; $display("FAIL rnd_stall s%0d c%0d: idle %0d cycles want <=1", seg, n, idle_run); end
                end
                if (imem_req) begin
                    if (!outstanding) begin
                        outstanding = 1'b1; tainted = 1'b0; req_addr = imem_addr; delay = $urandom_range(0, 3);
                        tests++; if (imem_addr !== pc) begin fails++; $display("FAIL rnd_req_pc s%0d c%0d: got %h want %h", seg, n, imem_addr, pc); end
                    end else begin
                        tests++; if (imem_addr !== req_addr) begin fails++; $display("FAIL rnd_addr_stable s%0d c%0d: got %h want %h", seg, n, imem_addr, req_addr); end
                    end
                    if (delay == 0) begin
                        imem_ack = 1'b1; imem_err = $urandom_range(0, 149) == 0; imem_rdata = memfn(req_addr);
                    end else delay--;
                end else outstanding = 1'b0;
                #1;
                aligned = redirect_pc[1:0] == 2'b00;
                acc = !fault_m && imem_ack && !imem_err && !tainted && !redirect_valid;
                if (fault_m) exp_cmd = NONE;
                else if (redirect_valid) exp_cmd = aligned ? LOAD : NONE;
                else if (acc) exp_cmd = INC;
                else exp_cmd = NONE;
                tests++; if (pc_cmd !== exp_cmd) begin fails++; $display("FAIL rnd_cmd s%0d c%0d: got %0d want %0d", seg, n, pc_cmd, exp_cmd); end
                if (exp_cmd == LOAD) begin
                    tests++; if (load_pc !== redirect_pc) begin fails++; $display("FAIL rnd_load_pc s%0d c%0d: got %h want %h", seg, n, load_pc, redirect_pc); end
                end
                if (acc) begin
                    tests++; if (req_addr !== exp_next) begin fails++; $display("FAIL rnd_seq s%0d c%0d: fetched %h want %h", seg, n, req_addr, exp_next); end
                end
                if (!fault_m && ((redirect_valid && !aligned) || (imem_ack && imem_err && !tainted && !redirect_valid))) begin
                    fault_m = 1'b1; held = 1'b0;
                end else if (!fault_m) begin
                    if (redirect_valid) begin held = 1'b0; exp_next = redirect_pc; end
                    else if (held && inst_ready) held = 1'b0;
                    if (acc) begin held = 1'b1; held_word = memfn(req_addr); exp_next = exp_next + 32'd4; end
                end
                if (imem_ack) outstanding = 1'b0;
                else if (outstanding && redirect_valid) tainted = 1'b1;
                step();
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_delayed_ack();
        test_hold_redirect();
        test_redirect_pending();
        test_bus_error();
        test_misaligned();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
